if_stage: RTL and testbench
===========================

IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, instruction and PC width.
REQ-002 The block SHALL have parameter IMEM_ADDR_WIDTH, default 8, word-address width (256-word instruction memory).
REQ-003 The block SHALL have port i_clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port i_reset, input, 1, reset that is asynchronous and active-high.
REQ-005 The block SHALL have port i_stall, input, 1, hold PC and IF/ID latch (from hazard unit).
REQ-006 The block SHALL have port i_flush, input, 1, load a bubble into the IF/ID latch (taken branch/jump).
REQ-007 The block SHALL have port i_pc_src, input, 1, 1 = next PC is i_jump_addr.
REQ-008 The block SHALL have port i_jump_addr, input, DATA_WIDTH, redirect target byte address.
REQ-009 The block SHALL have port i_load_en, input, 1, program-load mode.
REQ-010 The block SHALL have port i_load_addr, input, IMEM_ADDR_WIDTH, word address to write.
REQ-011 The block SHALL have port i_load_data, input, DATA_WIDTH, instruction word to write.
REQ-012 The block SHALL have port o_instruction, output, DATA_WIDTH, IF/ID latched instruction (feeds decode and register-bank rs/rt addressing).
REQ-013 The block SHALL have port o_pc_plus4, output, DATA_WIDTH, IF/ID latched PC+4.
REQ-014 The block SHALL have port o_valid, output, 1, IF/ID latch holds a real fetched instruction.
REQ-015 The block SHALL have port o_pc, output, DATA_WIDTH, current PC register value.
REQ-016 The block SHALL have port o_halt, output, 1, halt-detected flag (see Configuration).

Function
REQ-017 The instruction memory SHALL be read combinationally at index PC[IMEM_ADDR_WIDTH+1:2]; PC bits above that index SHALL be ignored, so fetch wraps every 2^IMEM_ADDR_WIDTH words.
REQ-018 PC update priority per edge SHALL be: i_load_en (PC <= 0) > halted (hold) > i_pc_src (PC <= {i_jump_addr[31:2],2'b00}) > i_stall (hold) > PC <= PC+4, mod 2^32.
REQ-019 IF/ID latch priority per edge SHALL be: i_load_en or i_flush (instruction 0x00000000, o_pc_plus4 0, o_valid 0) > i_stall or halted (hold) > capture {imem[PC], PC+4, valid 1}.
REQ-020 Fetch latency SHALL be one cycle: the word at PC appears on o_instruction after the next rising edge.
REQ-021 With i_load_en high, imem[i_load_addr] SHALL be written with i_load_data at the rising edge; writes with i_load_en low SHALL NOT occur.
REQ-022 Deasserting i_load_en SHALL start fetch at PC 0 on the following edge, with o_valid rising one cycle later.
REQ-023 Simultaneous i_stall and i_pc_src SHALL redirect PC while the latch holds; a flush in the same cycle SHALL bubble the latch.
REQ-024 Memory contents SHALL NOT be altered by reset or flush.

Reset
REQ-025 While i_reset is high, PC, o_instruction, o_pc_plus4 SHALL be 0 and o_valid and o_halt SHALL be 0, independent of i_clk.
REQ-026 Reset asserted mid-operation SHALL abandon any in-flight fetch; the first post-reset edge SHALL fetch imem[0].

Configuration
REQ-027 With macro IF_HALT_DETECT_EN defined, capturing 0xFFFFFFFF into the latch SHALL set a sticky halted state: o_halt=1, PC and latch frozen, until i_reset or i_load_en.
REQ-028 Without IF_HALT_DETECT_EN, 0xFFFFFFFF SHALL be fetched as an ordinary word and o_halt SHALL be tied to 0.

Verification
REQ-029 Load imem[0..2]=0x20010005,0x20020003,0x00221820, release load -> o_instruction sequence 0x20010005,0x20020003,0x00221820 on consecutive cycles, o_pc_plus4 4,8,12, o_valid 1.
REQ-030 Stall high 2 cycles at PC=8 -> o_pc stays 8, o_instruction holds 0x20020003 for 2 cycles, then resumes.
REQ-031 i_pc_src=1, i_jump_addr=0x00000043, i_flush=1 at PC=4 -> next o_pc=0x40, o_instruction=0, o_valid=0; next edge latches imem[16].
REQ-032 PC=0x3FC with IMEM_ADDR_WIDTH=8 -> next fetch address 0x400 reads imem[0].
REQ-033 IF_HALT_DETECT_EN defined, imem[3]=0xFFFFFFFF -> o_halt=1 after it latches, o_pc frozen at 0x10 for 10 cycles; without macro o_halt stays 0 and PC reaches 0x14.
REQ-034 Assert i_reset asynchronously mid-cycle with PC=0x20 -> o_pc, o_instruction, o_valid 0 immediately, before next i_clk edge.

Source files
------------

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, loadable word-addressed instruction memory and IF/ID latch.
// Optional halt detection on an all-ones instruction is enabled by defining IF_HALT_DETECT_EN.
module if_stage #(
    parameter int DATA_WIDTH      = 32,
    parameter int IMEM_ADDR_WIDTH = 8
) (
    input  logic                       i_clk,
    input  logic                       i_reset,
    input  logic                       i_stall,
    input  logic                       i_flush,
    input  logic                       i_pc_src,
    input  logic [DATA_WIDTH-1:0]      i_jump_addr,
    input  logic                       i_load_en,
    input  logic [IMEM_ADDR_WIDTH-1:0] i_load_addr,
    input  logic [DATA_WIDTH-1:0]      i_load_data,
    output logic [DATA_WIDTH-1:0]      o_instruction,
    output logic [DATA_WIDTH-1:0]      o_pc_plus4,
    output logic                       o_valid,
    output logic [DATA_WIDTH-1:0]      o_pc,
    output logic                       o_halt
);

    localparam int ImemDepth = 1 << IMEM_ADDR_WIDTH;

    logic [DATA_WIDTH-1:0]      r_imem [ImemDepth];
    logic [DATA_WIDTH-1:0]      r_pc;
    logic [DATA_WIDTH-1:0]      r_instr;
    logic [DATA_WIDTH-1:0]      r_pc_plus4;
    logic                       r_valid;

    logic [DATA_WIDTH-1:0]      w_pc_next;
    logic [DATA_WIDTH-1:0]      w_pc_plus4;
    logic [DATA_WIDTH-1:0]      w_jump_target;
    logic [IMEM_ADDR_WIDTH-1:0] w_fetch_idx;
    logic [DATA_WIDTH-1:0]      w_fetch_word;
    logic [DATA_WIDTH-1:0]      w_instr_next;
    logic [DATA_WIDTH-1:0]      w_pc_plus4_next;
    logic                       w_valid_next;
    logic                       w_capture;
    logic                       w_halted;
    logic                       w_unused_jump_lsbs;

    assign w_pc_plus4    = r_pc + DATA_WIDTH'(4);
    assign w_jump_target = {i_jump_addr[DATA_WIDTH-1:2], 2'b00};
    // Upper PC bits are dropped so fetch wraps around the memory.
    assign w_fetch_idx   = r_pc[IMEM_ADDR_WIDTH+1:2];
    assign w_fetch_word  = r_imem[w_fetch_idx];

    assign w_unused_jump_lsbs = ^i_jump_addr[1:0];

    // Memory has no reset so program contents survive reset and flush.
    always_ff @(posedge i_clk) begin
        if (i_load_en) begin
            r_imem[i_load_addr] <= i_load_data;
        end
    end

    always_comb begin
        w_pc_next = r_pc;
        if (i_load_en) begin
            w_pc_next = '0;
        end else if (w_halted) begin
            w_pc_next = r_pc;
        end else if (i_pc_src) begin
            w_pc_next = w_jump_target;
        end else if (i_stall) begin
            w_pc_next = r_pc;
        end else begin
            w_pc_next = w_pc_plus4;
        end
    end

    always_comb begin
        w_instr_next    = r_instr;
        w_pc_plus4_next = r_pc_plus4;
        w_valid_next    = r_valid;
        w_capture       = 1'b0;
        if (i_load_en || i_flush) begin
            w_instr_next    = '0;
            w_pc_plus4_next = '0;
            w_valid_next    = 1'b0;
        end else if (i_stall || w_halted) begin
            w_instr_next    = r_instr;
            w_pc_plus4_next = r_pc_plus4;
            w_valid_next    = r_valid;
        end else begin
            w_instr_next    = w_fetch_word;
            w_pc_plus4_next = w_pc_plus4;
            w_valid_next    = 1'b1;
            w_capture       = 1'b1;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_pc       <= '0;
            r_instr    <= '0;
            r_pc_plus4 <= '0;
            r_valid    <= 1'b0;
        end else begin
            r_pc       <= w_pc_next;
            r_instr    <= w_instr_next;
            r_pc_plus4 <= w_pc_plus4_next;
            r_valid    <= w_valid_next;
        end
    end

`ifdef IF_HALT_DETECT_EN
    logic r_halt;
    logic w_halt_next;

    // Sticky until reset or a program load.
    always_comb begin
        w_halt_next = r_halt;
        if (i_load_en) begin
            w_halt_next = 1'b0;
        end else if (w_capture && (w_fetch_word == {DATA_WIDTH{1'b1}})) begin
            w_halt_next = 1'b1;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_halt <= 1'b0;
        end else begin
            r_halt <= w_halt_next;
        end
    end

    assign w_halted = r_halt;
    assign o_halt   = r_halt;
`else
    assign w_halted = 1'b0;
    assign o_halt   = 1'b0;
`endif

    assign o_instruction = r_instr;
    assign o_pc_plus4    = r_pc_plus4;
    assign o_valid       = r_valid;
    assign o_pc          = r_pc;

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a behavioural fetch model.
module tb_if_stage;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        flush;
    logic        pc_src;
    logic [31:0] jump_addr;
    logic        load_en;
    logic [7:0]  load_addr;
    logic [31:0] load_data;
    logic [31:0] o_instruction;
    logic [31:0] o_pc_plus4;
    logic        o_valid;
    logic [31:0] o_pc;
    logic        o_halt;

`ifdef IF_HALT_DETECT_EN
    localparam logic HaltEn = 1'b1;
`else
    localparam logic HaltEn = 1'b0;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    if_stage #(
        .DATA_WIDTH     (32),
        .IMEM_ADDR_WIDTH(8)
    ) dut (
        .i_clk        (clk),
        .i_reset      (rst),
        .i_stall      (stall),
        .i_flush      (flush),
        .i_pc_src     (pc_src),
        .i_jump_addr  (jump_addr),
        .i_load_en    (load_en),
        .i_load_addr  (load_addr),
        .i_load_data  (load_data),
        .o_instruction(o_instruction),
        .o_pc_plus4   (o_pc_plus4),
        .o_valid      (o_valid),
        .o_pc         (o_pc),
        .o_halt       (o_halt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: memory array, PC and the latched fetch result.
    logic [31:0] m_mem [256];
    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic [31:0] m_pp4;
    logic        m_valid;
    logic        m_halted;

    always @(posedge clk) begin
        logic [31:0] fetched;
        logic        was_halted;
        logic        cap;
        if (rst) begin
            m_pc = 0; m_instr = 0; m_pp4 = 0; m_valid = 0; m_halted = 0;
        end else if (load_en) begin
            m_mem[load_addr] = load_data;
            m_pc = 0; m_instr = 0; m_pp4 = 0; m_valid = 0; m_halted = 0;
        end else begin
            fetched    = m_mem[(m_pc / 4) % 256];
            was_halted = m_halted;
            cap        = 1'b0;
            if (flush) begin
                m_instr = 0; m_pp4 = 0; m_valid = 0;
            end else if (!stall && !was_halted) begin
                m_instr = fetched; m_pp4 = m_pc + 4; m_valid = 1; cap = 1'b1;
            end
            if (!was_halted) begin
                if (pc_src)      m_pc = jump_addr & 32'hFFFF_FFFC;
                else if (!stall) m_pc = m_pc + 4;
            end
            if (HaltEn && cap && fetched == 32'hFFFF_FFFF) m_halted = 1;
        end
    end

    always @(posedge clk) begin
        #1;
        if (!rst) begin
            chk("model_pc", o_pc, m_pc);
            chk("model_instr", o_instruction, m_instr);
            chk("model_pc_plus4", o_pc_plus4, m_pp4);
            chk("model_valid", 32'(o_valid), 32'(m_valid));
            chk("model_halt", 32'(o_halt), 32'(m_halted));
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic load_word(input logic [7:0] a, input logic [31:0] d);
        load_en   = 1'b1;
        load_addr = a;
        load_data = d;
        tick();
    endtask

    task automatic reset_cycle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        logic [31:0] w;
        rst = 1'b1; load_en = 1'b1; stall = 0; flush = 0; pc_src = 0;
        jump_addr = 0; load_addr = 0; load_data = 0;
        #3;
        chk("rst_pc", o_pc, 32'h0);
        chk("rst_instr", o_instruction, 32'h0);
        chk("rst_pc_plus4", o_pc_plus4, 32'h0);
        chk("rst_valid", 32'(o_valid), 32'h0);
        chk("rst_halt", 32'(o_halt), 32'h0);
        @(posedge clk);
        #2;
        rst = 1'b0;

        for (int i = 0; i < 256; i++) begin
            w = $urandom;
            if (w == 32'hFFFF_FFFF) w = 32'h0;
            if (i == 0)   w = 32'h2001_0005;
            if (i == 1)   w = 32'h2002_0003;
            if (i == 2)   w = 32'h0022_1820;
            if (i == 16)  w = 32'h0000_1610;
            if (i == 255) w = 32'h00FF_00FF;
            load_word(8'(i), w);
        end
        load_en = 1'b0;
        chk("load_valid_low", 32'(o_valid), 32'h0);

        // Program fetch sequence after load release
        tick();
        chk("seq0_instr", o_instruction, 32'h2001_0005);
        chk("seq0_pp4", o_pc_plus4, 32'd4);
        chk("seq0_valid", 32'(o_valid), 32'h1);
        tick();
        chk("seq1_instr", o_instruction, 32'h2002_0003);
        chk("seq1_pp4", o_pc_plus4, 32'd8);
        tick();
        chk("seq2_instr", o_instruction, 32'h0022_1820);
        chk("seq2_pp4", o_pc_plus4, 32'd12);

        // Stall two cycles at PC=8
        reset_cycle();
        tick();
        tick();
        chk("stall_pre_pc", o_pc, 32'h8);
        stall = 1'b1;
        for (int k = 0; k < 2; k++) begin
            tick();
            chk("stall_pc", o_pc, 32'h8);
            chk("stall_instr", o_instruction, 32'h2002_0003);
        end
        stall = 1'b0;
        tick();
        chk("stall_resume_instr", o_instruction, 32'h0022_1820);
        chk("stall_resume_pc", o_pc, 32'hC);

        // Redirect with flush at PC=4
        reset_cycle();
        tick();
        chk("jmp_pre_pc", o_pc, 32'h4);
        pc_src = 1'b1; jump_addr = 32'h43; flush = 1'b1;
        tick();
        chk("jmp_pc", o_pc, 32'h40);
        chk("jmp_instr", o_instruction, 32'h0);
        chk("jmp_valid", 32'(o_valid), 32'h0);
        chk("jmp_pp4", o_pc_plus4, 32'h0);
        pc_src = 1'b0; flush = 1'b0;
        tick();
        chk("jmp_target_instr", o_instruction, 32'h0000_1610);
        chk("jmp_target_pp4", o_pc_plus4, 32'h44);

        // Fetch wraps past the top of memory
        pc_src = 1'b1; jump_addr = 32'h3FC;
        tick();
        chk("wrap_pc", o_pc, 32'h3FC);
        pc_src = 1'b0;
        tick();
        chk("wrap_top_instr", o_instruction, 32'h00FF_00FF);
        chk("wrap_next_pc", o_pc, 32'h400);
        tick();
        chk("wrap_instr", o_instruction, 32'h2001_0005);
        chk("wrap_pp4", o_pc_plus4, 32'h404);

        // Asynchronous reset mid-cycle at PC=0x20
        reset_cycle();
        repeat (8) tick();
        chk("areset_pre_pc", o_pc, 32'h20);
        #2;
        rst = 1'b1;
        #1;
        chk("areset_pc", o_pc, 32'h0);
        chk("areset_instr", o_instruction, 32'h0);
        chk("areset_valid", 32'(o_valid), 32'h0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        tick();
        chk("post_reset_instr", o_instruction, 32'h2001_0005);
        chk("post_reset_pc", o_pc, 32'h4);

        // All-ones instruction at word 3
        load_word(8'd3, 32'hFFFF_FFFF);
        load_en = 1'b0;
        repeat (4) tick();
        chk("halt_instr", o_instruction, 32'hFFFF_FFFF);
        chk("halt_pc", o_pc, 32'h10);
        chk("halt_flag", 32'(o_halt), 32'(HaltEn));
`ifdef IF_HALT_DETECT_EN
        for (int k = 0; k < 10; k++) begin
            tick();
            chk("halt_frozen_pc", o_pc, 32'h10);
            chk("halt_frozen_flag", 32'(o_halt), 32'h1);
        end
`else
        tick();
        chk("nohalt_pc", o_pc, 32'h14);
        chk("nohalt_flag", 32'(o_halt), 32'h0);
`endif
        load_word(8'd3, 32'h0000_0003);
        chk("halt_cleared", 32'(o_halt), 32'h0);
        load_en = 1'b0;

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            load_en   = ($urandom_range(99) < 5);
            load_addr = 8'($urandom);
            load_data = ($urandom_range(99) < 3) ? 32'hFFFF_FFFF : $urandom;
            stall     = ($urandom_range(99) < 20);
            flush     = ($urandom_range(99) < 10);
            pc_src    = ($urandom_range(99) < 10);
            jump_addr = $urandom;
            if (!rst && $urandom_range(99) == 0) begin
                rst = 1'b1;
                #1;
                chk("rand_areset_pc", o_pc, 32'h0);
                chk("rand_areset_valid", 32'(o_valid), 32'h0);
            end else begin
                rst = 1'b0;
            end
            tick();
        end
        rst = 0; load_en = 0; stall = 0; flush = 0; pc_src = 0;
        tick();
        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
